// File: rtl/fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_pkg                                                           |
// | Shared sizing and pointer helpers for the parametrised FIFO.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package fifo_pkg;

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Explicit wrap so non-power-of-two depths use exactly DEPTH slots.
  function automatic int ptr_next(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_param_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_fifo_param_if                                                 |
// | Producer/consumer handshake and status bundle for sync_fifo_param. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) ();
  localparam int CW = count_width(DEPTH);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, count, empty, full,
    input  almost_empty, almost_full, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, count, empty, full,
    output almost_empty, almost_full, overflow, underflow
  );
endinterface
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fifo_mem                                                           |
// | Simple dual-port register array, one write port, registered read.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = ptr_width(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             wr_en,
  input  wire logic [AW-1:0]    wr_addr,
  input  wire logic [WIDTH-1:0] wr_data,
  input  wire logic             rd_en,
  input  wire logic [AW-1:0]    rd_addr,
  output logic      [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage is deliberately unreset so it can map onto block RAM later.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= r_mem[rd_addr];
    end
  end
endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_fifo_param                                                    |
// | Single-clock FIFO with thresholds, occupancy and error pulses.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input wire logic           clk,
  input wire logic           reset_n,
  sync_fifo_param_if.slave   bus
);
  localparam int CW = count_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_rd_valid;
  logic          r_overflow;
  logic          r_underflow;
  logic          w_full;
  logic          w_empty;
  logic          w_wr_acc;
  logic          w_rd_acc;

  // Flags come only from the registered count, never from the requests.
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = bus.wr_en && !w_full;
  assign w_rd_acc = bus.rd_en && !w_empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rd_valid  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= PW'(ptr_next(int'(r_wr_ptr), DEPTH));
      end
      if (w_rd_acc) begin
        r_rd_ptr <= PW'(ptr_next(int'(r_rd_ptr), DEPTH));
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_rd_valid  <= w_rd_acc;
      r_overflow  <= bus.wr_en && w_full;
      r_underflow <= bus.rd_en && w_empty;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (w_wr_acc),
    .wr_addr (r_wr_ptr),
    .wr_data (bus.wr_data),
    .rd_en   (w_rd_acc),
    .rd_addr (r_rd_ptr),
    .rd_data (bus.rd_data)
  );

  assign bus.rd_valid     = r_rd_valid;
  assign bus.count        = r_count;
  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_empty = (r_count <= CW'(AE_LEVEL));
  assign bus.almost_full  = (r_count >= CW'(AF_LEVEL));
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sync_fifo_param                                                 |
// | Queue-model bench for two FIFO instances (depth 8 and depth 5).    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_sync_fifo_param;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(8), .DEPTH(8)) f8 ();
  sync_fifo_param_if #(.WIDTH(8), .DEPTH(5)) f5 ();

  sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1)) dut8 (
    .clk(clk), .reset_n(reset_n), .bus(f8.slave));
  sync_fifo_param #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut5 (
    .clk(clk), .reset_n(reset_n), .bus(f5.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue per FIFO plus the last popped word and pulses.
  logic [7:0] q8[$];
  logic [7:0] q5[$];
  logic [7:0] m8_data = '0, m5_data = '0;
  logic       m8_vld = 0, m8_ovf = 0, m8_unf = 0;
  logic       m5_vld = 0, m5_ovf = 0, m5_unf = 0;
  bit         seen_reset = 0;

  initial forever begin
    @(negedge clk);
    if (seen_reset) begin
      chk("d8_count", 32'(f8.count), 32'(q8.size()));
      chk("d8_empty", 32'(f8.empty), 32'(q8.size() == 0));
      chk("d8_full", 32'(f8.full), 32'(q8.size() == 8));
      chk("d8_aempty", 32'(f8.almost_empty), 32'(q8.size() <= 1));
      chk("d8_afull", 32'(f8.almost_full), 32'(q8.size() >= 7));
      chk("d8_rd_valid", 32'(f8.rd_valid), 32'(m8_vld));
      chk("d8_rd_data", 32'(f8.rd_data), 32'(m8_data));
      chk("d8_overflow", 32'(f8.overflow), 32'(m8_ovf));
      chk("d8_underflow", 32'(f8.underflow), 32'(m8_unf));
      chk("d5_count", 32'(f5.count), 32'(q5.size()));
      chk("d5_empty", 32'(f5.empty), 32'(q5.size() == 0));
      chk("d5_full", 32'(f5.full), 32'(q5.size() == 5));
      chk("d5_aempty", 32'(f5.almost_empty), 32'(q5.size() <= 1));
      chk("d5_afull", 32'(f5.almost_full), 32'(q5.size() >= 4));
      chk("d5_rd_valid", 32'(f5.rd_valid), 32'(m5_vld));
      chk("d5_rd_data", 32'(f5.rd_data), 32'(m5_data));
      chk("d5_overflow", 32'(f5.overflow), 32'(m5_ovf));
      chk("d5_underflow", 32'(f5.underflow), 32'(m5_unf));
    end
    // Advance the model by the edge that will sample the current inputs.
    if (!reset_n) begin
      q8.delete(); q5.delete();
      m8_data = '0; m8_vld = 0; m8_ovf = 0; m8_unf = 0;
      m5_data = '0; m5_vld = 0; m5_ovf = 0; m5_unf = 0;
      seen_reset = 1;
    end else begin
      m8_ovf = f8.wr_en && (q8.size() == 8);
      m8_unf = f8.rd_en && (q8.size() == 0);
      m8_vld = f8.rd_en && (q8.size() != 0);
      if (m8_vld) m8_data = q8.pop_front();
      if (f8.wr_en && !m8_ovf) q8.push_back(f8.wr_data);
      m5_ovf = f5.wr_en && (q5.size() == 5);
      m5_unf = f5.rd_en && (q5.size() == 0);
      m5_vld = f5.rd_en && (q5.size() != 0);
      if (m5_vld) m5_data = q5.pop_front();
      if (f5.wr_en && !m5_ovf) q5.push_back(f5.wr_data);
    end
  end

  task automatic cyc8(input logic wr, input logic rd, input logic [7:0] d);
    f8.wr_en = wr; f8.rd_en = rd; f8.wr_data = d;
    @(posedge clk); #1;
    f8.wr_en = 0; f8.rd_en = 0;
  endtask

  task automatic cyc5(input logic wr, input logic rd, input logic [7:0] d);
    f5.wr_en = wr; f5.rd_en = rd; f5.wr_data = d;
    @(posedge clk); #1;
    f5.wr_en = 0; f5.rd_en = 0;
  endtask

  initial begin
    int sent;
    int popped;
    f8.wr_en = 0; f8.rd_en = 0; f8.wr_data = '0;
    f5.wr_en = 0; f5.rd_en = 0; f5.wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    chk("rst_count", 32'(f8.count), 0);
    chk("rst_empty", 32'(f8.empty), 1);
    chk("rst_rd_valid", 32'(f8.rd_valid), 0);
    chk("rst_rd_data", 32'(f8.rd_data), 0);
    chk("rst_aempty", 32'(f8.almost_empty), 1);

    // Fill and drain
    for (int i = 1; i <= 8; i++) begin
      cyc8(1, 0, 8'(i));
      if (i == 6) chk("afull_at6", 32'(f8.almost_full), 0);
      if (i == 7) chk("afull_at7", 32'(f8.almost_full), 1);
    end
    chk("fill_count", 32'(f8.count), 8);
    chk("fill_full", 32'(f8.full), 1);
    for (int i = 1; i <= 8; i++) begin
      cyc8(0, 1, 8'h00);
      chk("drain_data", 32'(f8.rd_data), 32'(i));
      chk("drain_valid", 32'(f8.rd_valid), 1);
    end
    chk("drain_empty", 32'(f8.empty), 1);

    // Both requested while empty
    cyc8(1, 1, 8'h55);
    chk("both_empty_count", 32'(f8.count), 1);
    chk("both_empty_unf", 32'(f8.underflow), 1);
    chk("both_empty_vld", 32'(f8.rd_valid), 0);
    cyc8(0, 1, 8'h00);
    chk("both_empty_data", 32'(f8.rd_data), 32'h55);

    // Simultaneous read/write at count 4
    for (int i = 0; i < 4; i++) cyc8(1, 0, 8'(8'h10 + i));
    for (int i = 0; i < 10; i++) begin
      cyc8(1, 1, 8'(8'h20 + i));
      if (i == 0) chk("simul_first", 32'(f8.rd_data), 32'h10);
      if (i == 9) chk("simul_last", 32'(f8.rd_data), 32'h25);
    end
    chk("simul_count", 32'(f8.count), 4);

    // Both requested while full, then overflow burst
    for (int i = 0; i < 4; i++) cyc8(1, 0, 8'(8'h30 + i));
    cyc8(1, 1, 8'hEE);
    chk("both_full_count", 32'(f8.count), 7);
    chk("both_full_ovf", 32'(f8.overflow), 1);
    chk("both_full_data", 32'(f8.rd_data), 32'h26);
    cyc8(1, 0, 8'h34);
    for (int i = 0; i < 3; i++) begin
      cyc8(1, 0, 8'(8'hF0 + i));
      chk("ovf_pulse", 32'(f8.overflow), 1);
      chk("ovf_count", 32'(f8.count), 8);
    end
    for (int i = 0; i < 8; i++) begin
      cyc8(0, 1, 8'h00);
      if (i == 0) chk("post_ovf_first", 32'(f8.rd_data), 32'h27);
      if (i == 7) chk("post_ovf_last", 32'(f8.rd_data), 32'h34);
    end
    cyc8(0, 1, 8'h00);
    chk("unf_pulse", 32'(f8.underflow), 1);
    chk("unf_vld", 32'(f8.rd_valid), 0);
    chk("unf_hold", 32'(f8.rd_data), 32'h34);

    // Wrap-around on depth 5: preload 2, then bursts of 3 in and 3 out
    sent = 0;
    popped = 0;
    for (int i = 0; i < 2; i++) begin
      cyc5(1, 0, 8'(8'h40 + sent));
      sent++;
    end
    while (sent < 13) begin
      for (int j = 0; j < 3; j++) begin
        if (sent < 13) begin
          cyc5(1, 0, 8'(8'h40 + sent));
          sent++;
        end
      end
      for (int j = 0; j < 3; j++) begin
        cyc5(0, 1, 8'h00);
        if (f5.rd_valid) popped++;
      end
    end
    for (int j = 0; j < 4; j++) begin
      cyc5(0, 1, 8'h00);
      if (f5.rd_valid) popped++;
    end
    chk("wrap_popped", 32'(popped), 13);
    chk("wrap_last", 32'(f5.rd_data), 32'h4C);
    chk("wrap_empty", 32'(f5.empty), 1);

    // Reset mid-stream with a write pending
    for (int i = 0; i < 5; i++) cyc8(1, 0, 8'(8'h61 + i));
    reset_n = 0;
    f8.wr_en = 1; f8.wr_data = 8'h77;
    @(posedge clk); #1;
    reset_n = 1;
    f8.wr_en = 0;
    chk("mid_rst_count", 32'(f8.count), 0);
    chk("mid_rst_empty", 32'(f8.empty), 1);
    cyc8(1, 0, 8'hAA);
    cyc8(0, 1, 8'h00);
    chk("mid_rst_data", 32'(f8.rd_data), 32'hAA);
    chk("mid_rst_vld", 32'(f8.rd_valid), 1);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
